// File: rtl/vga_pkg.sv
// Shared VGA constants, pattern mode encoding and colour values for the
// pattern-generation stage.
package vga_pkg;

    localparam int H_DISPLAY = 640;
    localparam int V_DISPLAY = 480;

    typedef enum logic [1:0] {
        MODE_BARS    = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_BOX     = 2'd2
    } mode_t;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] BLUE  = 3'b001;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] WHITE = 3'b111;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_BARS:    next_mode = MODE_CHECKER;
            MODE_CHECKER: next_mode = MODE_BOX;
            default:      next_mode = MODE_BARS;
        endcase
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position: both axes step by SPEED once per tick and reverse
// at the screen edges, clamping so the box never leaves the visible area.
module vga_box_mover
    import vga_pkg::*;
#(
    parameter int BOX_SIZE = 32,
    parameter int SPEED    = 2
) (
    input  logic       clk_25,
    input  logic       reset,
    input  logic       tick,
    output logic [9:0] box_x,
    output logic [9:0] box_y
);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            // Axis 0 is horizontal, axis 1 vertical; only the far limit differs.
            localparam int MAX_POS = (gi == 0) ? (H_DISPLAY - BOX_SIZE) : (V_DISPLAY - BOX_SIZE);

            logic [9:0] pos_reg;
            logic       back_reg;   // 0: right/down, 1: left/up

            always_ff @(posedge clk_25) begin
                if (reset) begin
                    pos_reg  <= '0;
                    back_reg <= 1'b0;
                end else if (tick) begin
                    if (!back_reg) begin
                        if (pos_reg >= 10'(MAX_POS - SPEED)) begin
                            pos_reg  <= 10'(MAX_POS);
                            back_reg <= 1'b1;
                        end else begin
                            pos_reg <= pos_reg + 10'(SPEED);
                        end
                    end else begin
                        if (pos_reg <= 10'(SPEED)) begin
                            pos_reg  <= '0;
                            back_reg <= 1'b0;
                        end else begin
                            pos_reg <= pos_reg - 10'(SPEED);
                        end
                    end
                end
            end
        end
    endgenerate

    assign box_x = g_axis[0].pos_reg;
    assign box_y = g_axis[1].pos_reg;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel stage: cycles bars/checker/box on frame boundaries and
// emits a registered pixel with syncs delayed two cycles to stay aligned.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int FRAMES_PER_MODE = 120,
    parameter int BOX_SIZE        = 32,
    parameter int SPEED           = 2,
    parameter int CHECK_LOG2      = 5
) (
    input  logic       clk_25,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       display_on,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    output logic [2:0] pixel,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       frame_tick
);

    logic       frame_boundary;
    mode_t      mode_reg;
    logic [7:0] frame_cnt_reg;
    logic       frame_tick_reg;
    logic [9:0] box_x;
    logic [9:0] box_y;

    // Row 480 is the first blanking row, so switching here never tears.
    assign frame_boundary = (hpos == 10'd0) && (vpos == 10'(V_DISPLAY));

    always_ff @(posedge clk_25) begin
        if (reset) begin
            mode_reg       <= MODE_BARS;
            frame_cnt_reg  <= '0;
            frame_tick_reg <= 1'b0;
        end else begin
            frame_tick_reg <= frame_boundary;
            if (frame_boundary) begin
                if (frame_cnt_reg == 8'(FRAMES_PER_MODE - 1)) begin
                    frame_cnt_reg <= '0;
                    mode_reg      <= next_mode(mode_reg);
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + 8'd1;
                end
            end
        end
    end

    vga_box_mover #(
        .BOX_SIZE (BOX_SIZE),
        .SPEED    (SPEED)
    ) u_box (
        .clk_25 (clk_25),
        .reset  (reset),
        .tick   (frame_boundary),
        .box_x  (box_x),
        .box_y  (box_y)
    );

    logic [9:0] hpos_s1_reg;
    logic [9:0] vpos_s1_reg;
    logic       disp_s1_reg;
    logic       hsync_s1_reg;
    logic       vsync_s1_reg;

    always_ff @(posedge clk_25) begin
        if (reset) begin
            hpos_s1_reg  <= '0;
            vpos_s1_reg  <= '0;
            disp_s1_reg  <= 1'b0;
            hsync_s1_reg <= 1'b0;
            vsync_s1_reg <= 1'b0;
        end else begin
            hpos_s1_reg  <= hpos;
            vpos_s1_reg  <= vpos;
            disp_s1_reg  <= display_on;
            hsync_s1_reg <= hsync_in;
            vsync_s1_reg <= vsync_in;
        end
    end

    // Extra bit keeps box_x+BOX_SIZE from wrapping near the right edge.
    logic [10:0] box_x_end;
    logic [10:0] box_y_end;
    logic        box_hit;
    logic [2:0]  bar_colour;
    logic [2:0]  checker_colour;
    logic [2:0]  pixel_next;

    assign box_x_end = {1'b0, box_x} + 11'(BOX_SIZE);
    assign box_y_end = {1'b0, box_y} + 11'(BOX_SIZE);
    assign box_hit   = (hpos_s1_reg >= box_x) && ({1'b0, hpos_s1_reg} < box_x_end) &&
                       (vpos_s1_reg >= box_y) && ({1'b0, vpos_s1_reg} < box_y_end);
    assign bar_colour     = hpos_s1_reg[8:6];
    assign checker_colour = (hpos_s1_reg[CHECK_LOG2] ^ vpos_s1_reg[CHECK_LOG2]) ? WHITE : BLACK;

    always_comb begin
        pixel_next = BLACK;
        if (disp_s1_reg) begin
            case (mode_reg)
                MODE_BARS:    pixel_next = bar_colour;
                MODE_CHECKER: pixel_next = checker_colour;
                MODE_BOX:     pixel_next = box_hit ? RED : BLUE;
                default:      pixel_next = BLACK;
            endcase
        end
    end

    logic [2:0] pixel_reg;
    logic       hsync_out_reg;
    logic       vsync_out_reg;

    always_ff @(posedge clk_25) begin
        if (reset) begin
            pixel_reg     <= BLACK;
            hsync_out_reg <= 1'b0;
            vsync_out_reg <= 1'b0;
        end else begin
            pixel_reg     <= pixel_next;
            hsync_out_reg <= hsync_s1_reg;
            vsync_out_reg <= vsync_s1_reg;
        end
    end

    assign pixel      = pixel_reg;
    assign hsync_out  = hsync_out_reg;
    assign vsync_out  = vsync_out_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: reset, latency, pattern modes, mode
// cycling, box bounce limits and reset coinciding with a frame boundary.
module tb_vga_pattern_gen;
    import vga_pkg::*;

    logic       clk_25 = 1'b0;
    logic       reset = 1'b1;
    logic       hsync_in = 1'b0;
    logic       vsync_in = 1'b0;
    logic       display_on = 1'b0;
    logic [9:0] hpos = '0;
    logic [9:0] vpos = '0;
    logic [2:0] pixel;
    logic       hsync_out;
    logic       vsync_out;
    logic       frame_tick;

    int total = 0;
    int bad   = 0;

    always #20 clk_25 = ~clk_25;

    vga_pattern_gen #(
        .FRAMES_PER_MODE (2),
        .BOX_SIZE        (32),
        .SPEED           (2),
        .CHECK_LOG2      (5)
    ) dut (
        .clk_25     (clk_25),
        .reset      (reset),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .display_on (display_on),
        .hpos       (hpos),
        .vpos       (vpos),
        .pixel      (pixel),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .frame_tick (frame_tick)
    );

    task automatic step();
        @(posedge clk_25);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hpos = '0; vpos = '0; display_on = 1'b0;
        hsync_in = 1'b0; vsync_in = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic boundary();
        hpos = 10'd0; vpos = 10'd480; display_on = 1'b0;
        step();
        hpos = 10'd100; vpos = 10'd100;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        hpos = 10'd70; vpos = 10'd10; display_on = 1'b1;
        step(); step(); step();
        total++;
        if ({pixel, hsync_out, vsync_out, frame_tick} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs: got pixel=%b hs=%b vs=%b tick=%b, want all 0", pixel, hsync_out, vsync_out, frame_tick);
        end else $display("ok reset_outputs");
        reset = 1'b0;
        step();
        total++;
        if (hsync_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs_1cyc: got %b want 0", hsync_out);
        end else $display("ok reset_hs_1cyc");
        step();
        total++;
        if (hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
            bad++;
            $display("FAIL reset_hs_2cyc: got hs=%b vs=%b want 1 1", hsync_out, vsync_out);
        end else $display("ok reset_hs_2cyc");
        hsync_in = 1'b0;
        step(); step();
        total++;
        if (hsync_out !== 1'b0 || vsync_out !== 1'b1) begin
            bad++;
            $display("FAIL hs_follow_low: got hs=%b vs=%b want 0 1", hsync_out, vsync_out);
        end else $display("ok hs_follow_low");
        vsync_in = 1'b0;
    endtask

    task automatic test_latency_bars();
        logic [9:0] hv [3];
        logic [2:0] ex [3];
        do_reset();
        hpos = 10'd70; vpos = 10'd10; display_on = 1'b1;
        step();
        total++;
        if (pixel !== 3'b000) begin
            bad++;
            $display("FAIL bars_early: got %b want 000 after 1 cycle", pixel);
        end else $display("ok bars_early");
        step();
        total++;
        if (pixel !== 3'b001) begin
            bad++;
            $display("FAIL bars_x70: got %b want 001", pixel);
        end else $display("ok bars_x70");
        display_on = 1'b0;
        step();
        total++;
        if (pixel !== 3'b001) begin
            bad++;
            $display("FAIL blank_early: got %b want 001", pixel);
        end else $display("ok blank_early");
        step();
        total++;
        if (pixel !== 3'b000) begin
            bad++;
            $display("FAIL blank: got %b want 000", pixel);
        end else $display("ok blank");
        hv = '{10'd511, 10'd512, 10'd448};
        ex = '{3'b111, 3'b000, 3'b111};
        display_on = 1'b1; vpos = 10'd5;
        for (int i = 0; i < 3; i++) begin
            hpos = hv[i];
            step(); step();
            total++;
            if (pixel !== ex[i]) begin
                bad++;
                $display("FAIL bars_x%0d: got %b want %b", hv[i], pixel, ex[i]);
            end else $display("ok bars_x%0d", hv[i]);
        end
    endtask

    task automatic test_checker();
        logic [9:0] hx [3];
        logic [9:0] vy [3];
        logic [2:0] ex [3];
        do_reset();
        boundary(); boundary();
        hx = '{10'd32, 10'd32, 10'd0};
        vy = '{10'd0, 10'd32, 10'd0};
        ex = '{WHITE, BLACK, BLACK};
        display_on = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hpos = hx[i]; vpos = vy[i];
            display_on = 1'b1;
            step(); step();
            total++;
            if (pixel !== ex[i]) begin
                bad++;
                $display("FAIL checker_%0d_%0d: got %b want %b", hx[i], vy[i], pixel, ex[i]);
            end else $display("ok checker_%0d_%0d", hx[i], vy[i]);
        end
    endtask

    task automatic test_mode_cycle();
        mode_t exp_mode [6];
        logic [9:0] hx [5];
        logic [9:0] vy [5];
        logic [2:0] ex [5];
        exp_mode = '{MODE_BARS, MODE_CHECKER, MODE_CHECKER, MODE_BOX, MODE_BOX, MODE_BARS};
        hx = '{10'd8, 10'd7, 10'd39, 10'd40, 10'd8};
        vy = '{10'd8, 10'd8, 10'd39, 10'd8, 10'd40};
        ex = '{RED, BLUE, RED, BLUE, BLUE};
        do_reset();
        for (int f = 0; f < 6; f++) begin
            hpos = 10'd0; vpos = 10'd480; display_on = 1'b0;
            step();
            total++;
            if (frame_tick !== 1'b1) begin
                bad++;
                $display("FAIL tick_pulse_f%0d: got %b want 1", f + 1, frame_tick);
            end else $display("ok tick_pulse_f%0d", f + 1);
            hpos = 10'd100; vpos = 10'd100;
            step();
            total++;
            if (frame_tick !== 1'b0 || dut.mode_reg !== exp_mode[f]) begin
                bad++;
                $display("FAIL mode_f%0d: got tick=%b mode=%0d want tick=0 mode=%0d", f + 1, frame_tick, dut.mode_reg, exp_mode[f]);
            end else $display("ok mode_f%0d", f + 1);
            // box sits at (8,8) after four boundaries
            if (f == 3) begin
                for (int i = 0; i < 5; i++) begin
                    hpos = hx[i]; vpos = vy[i]; display_on = 1'b1;
                    step(); step();
                    total++;
                    if (pixel !== ex[i]) begin
                        bad++;
                        $display("FAIL box_px_%0d_%0d: got %b want %b", hx[i], vy[i], pixel, ex[i]);
                    end else $display("ok box_px_%0d_%0d", hx[i], vy[i]);
                end
                display_on = 1'b0;
            end
        end
    endtask

    task automatic test_box_bounce();
        do_reset();
        hpos = 10'd0; vpos = 10'd480; display_on = 1'b0;
        for (int n = 1; n <= 305; n++) begin
            step();
            if (n == 223 || n == 225) begin
                total++;
                if (dut.u_box.box_y !== 10'd446) begin
                    bad++;
                    $display("FAIL box_y_t%0d: got %0d want 446", n, dut.u_box.box_y);
                end else $display("ok box_y_t%0d", n);
            end
            if (n == 224) begin
                total++;
                if (dut.u_box.box_y !== 10'd448) begin
                    bad++;
                    $display("FAIL box_y_clamp: got %0d want 448", dut.u_box.box_y);
                end else $display("ok box_y_clamp");
            end
            if (n >= 302) begin
                logic [9:0] want;
                want = (n == 302) ? 10'd604 : (n == 304) ? 10'd608 : 10'd606;
                total++;
                if (dut.u_box.box_x !== want) begin
                    bad++;
                    $display("FAIL box_x_t%0d: got %0d want %0d", n, dut.u_box.box_x, want);
                end else $display("ok box_x_t%0d", n);
            end
        end
        hpos = 10'd100; vpos = 10'd100;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        boundary(); boundary(); boundary(); boundary();
        total++;
        if (dut.mode_reg !== MODE_BOX) begin
            bad++;
            $display("FAIL mid_pre_box: got mode=%0d want %0d", dut.mode_reg, MODE_BOX);
        end else $display("ok mid_pre_box");
        hpos = 10'd0; vpos = 10'd480; reset = 1'b1;
        step();
        total++;
        if (frame_tick !== 1'b0 || dut.mode_reg !== MODE_BARS || dut.frame_cnt_reg !== 8'd0 ||
            dut.u_box.box_x !== 10'd0 || dut.u_box.box_y !== 10'd0) begin
            bad++;
            $display("FAIL mid_reset_state: got tick=%b mode=%0d cnt=%0d box=(%0d,%0d) want 0,0,0,(0,0)",
                     frame_tick, dut.mode_reg, dut.frame_cnt_reg, dut.u_box.box_x, dut.u_box.box_y);
        end else $display("ok mid_reset_state");
        reset = 1'b0;
        hpos = 10'd70; vpos = 10'd10; display_on = 1'b1;
        step();
        total++;
        if (frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL mid_no_tick: got %b want 0", frame_tick);
        end else $display("ok mid_no_tick");
        step();
        total++;
        if (pixel !== 3'b001) begin
            bad++;
            $display("FAIL mid_bars_valid: got %b want 001", pixel);
        end else $display("ok mid_bars_valid");
        boundary();
        total++;
        if (dut.mode_reg !== MODE_BARS || dut.frame_cnt_reg !== 8'd1) begin
            bad++;
            $display("FAIL mid_full_count: got mode=%0d cnt=%0d want 0 1", dut.mode_reg, dut.frame_cnt_reg);
        end else $display("ok mid_full_count");
    endtask

    initial begin
        test_reset();
        test_latency_bars();
        test_checker();
        test_mode_cycle();
        test_box_bounce();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
